// File: rtl/rv32_mt_regfile.sv
// ---------------------------------------------------------------------------
// rv32_mt_regfile
// Multi-hart RV32 general-purpose register file with per-hart program
// counters and round-robin hart scheduling.
//
// After reset the array is cleared one entry per cycle (INIT). The block then
// enters RUN, where it serves two read ports and one write port for the
// scheduled hart.
//
// Ports
//   clk, reset_n      clock (rising edge), synchronous active-low reset
//   rs1_idx, rs2_idx  read indices for cur_hart
//   rd_idx, rd_we     write index and enable
//   new_rd            write data
//   wr_hart           hart owning the write and the PC update
//   new_pc, update_pc branch target and branch-taken strobe for wr_hart
//   stall             freezes scheduling, PC update and writes
//   rs1, rs2          read data, one cycle after the index is presented
//   pc, last_pc       PC of cur_hart, and PC-4 captured at the last advance
//   cur_hart          hart currently being fetched
//   init_done         high once the clear sequence has completed
// ---------------------------------------------------------------------------
module rv32_mt_regfile #(
   parameter int unsigned LOG2_REGFILE_ENTRIES = 5,
   parameter int unsigned LOG2_HARTS           = 1,
   parameter logic [31:0] RESET_VECTOR         = 32'h0000_0000
) (
   input  logic                                         clk,
   input  logic                                         reset_n,
   input  logic [4:0]                                   rs1_idx,
   input  logic [4:0]                                   rs2_idx,
   input  logic [4:0]                                   rd_idx,
   input  logic [((LOG2_HARTS > 0) ? LOG2_HARTS : 1)-1:0] wr_hart,
   input  logic                                         rd_we,
   input  logic [31:0]                                  new_rd,
   input  logic [31:0]                                  new_pc,
   input  logic                                         update_pc,
   input  logic                                         stall,
   output logic [31:0]                                  rs1,
   output logic [31:0]                                  rs2,
   output logic [31:0]                                  pc,
   output logic [31:0]                                  last_pc,
   output logic [((LOG2_HARTS > 0) ? LOG2_HARTS : 1)-1:0] cur_hart,
   output logic                                         init_done
);

   localparam int unsigned LRE       = LOG2_REGFILE_ENTRIES;
   localparam int unsigned HW        = (LOG2_HARTS > 0) ? LOG2_HARTS : 1;
   localparam int unsigned NH        = 2 ** LOG2_HARTS;
   localparam int unsigned NPC       = 2 ** HW;
   localparam int unsigned AW        = LRE + LOG2_HARTS;
   localparam int unsigned DEPTH     = 2 ** AW;
   localparam int unsigned NREG      = 2 ** LRE;

   localparam logic [HW-1:0] HART_MASK = HW'(NH - 1);
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   localparam logic [0:0] INIT = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   // {hart, index} flat address; hart bits vanish when there is a single hart
   function automatic logic [AW-1:0] mk_addr(input logic [HW-1:0] h,
                                             input logic [4:0]    idx);
      logic [31:0] a;
      a = (32'(h) << LRE) | (32'(idx) & 32'(NREG - 1));
      return AW'(a);
   endfunction

   // Read-port result: index 0 is hardwired, then current write, then the
   // write that landed after the array was sampled, then the array itself
   function automatic logic [31:0] rd_mux(input logic            vld,
                                          input logic [AW-1:0]   cap,
                                          input logic [31:0]     arr,
                                          input logic            cw_vld,
                                          input logic [AW-1:0]   cw_addr,
                                          input logic [31:0]     cw_data,
                                          input logic            pw_vld,
                                          input logic [AW-1:0]   pw_addr,
                                          input logic [31:0]     pw_data);
      logic [31:0] r;
      r = 32'h0;
      if (vld && (cap[LRE-1:0] != '0)) begin
         if (cw_vld && (cw_addr == cap))      r = cw_data;
         else if (pw_vld && (pw_addr == cap)) r = pw_data;
         else                                 r = arr;
      end
      return r;
   endfunction

   logic [0:0]    state_q, state_d;
   logic [AW-1:0] clr_q, clr_d;
   logic          init_done_q;

   logic [31:0]   mem [DEPTH];
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [31:0]   mem_wdata;

   logic          run;
   logic          adv;
   logic          rd_in_range;
   logic          wr_acc;
   logic [AW-1:0] wr_addr;

   logic [AW-1:0] rd1_addr, rd2_addr;
   logic [AW-1:0] cap1_q, cap2_q;
   logic          cap_vld_q;
   logic [31:0]   arr1_q, arr2_q;

   logic          pw_vld_q;
   logic [AW-1:0] pw_addr_q;
   logic [31:0]   pw_data_q;

   logic [HW-1:0] cur_q, cur_nxt, wr_h;
   logic [31:0]   pc_q [NPC];
   logic [31:0]   pc_cur;
   logic [31:0]   last_pc_q;

   assign run         = (state_q == RUN);
   assign adv         = run && !stall;
   assign rd_in_range = ((32'(rd_idx) >> LRE) == 32'd0);
   assign wr_h        = wr_hart & HART_MASK;
   assign wr_acc      = reset_n && adv && rd_we && (rd_idx != 5'd0) && rd_in_range;
   assign wr_addr     = mk_addr(wr_h, rd_idx);
   assign rd1_addr    = mk_addr(cur_q, rs1_idx);
   assign rd2_addr    = mk_addr(cur_q, rs2_idx);
   assign cur_nxt     = HW'((32'(cur_q) + 32'd1) & 32'(NH - 1));
   assign pc_cur      = pc_q[cur_q];

   // State register and clear counter
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= INIT;
         clr_q       <= '0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_q       <= clr_d;
         init_done_q <= (state_d == RUN);
      end
   end

   // Next state and array write port selection
   always_comb begin
      state_d   = state_q;
      clr_d     = clr_q;
      mem_we    = 1'b0;
      mem_waddr = wr_addr;
      mem_wdata = new_rd;
      case (state_q)
         INIT: begin
            mem_we    = reset_n;
            mem_waddr = clr_q;
            mem_wdata = 32'h0;
            clr_d     = clr_q + AW'(1);
            if (clr_q == LAST_ADDR) begin
               state_d = RUN;
               clr_d   = '0;
            end
         end
         RUN: begin
            mem_we = wr_acc;
         end
         default: begin
            state_d = INIT;
            clr_d   = '0;
         end
      endcase
   end

   // Storage array with registered read; the write of this edge is not seen
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
      arr1_q <= mem[rd1_addr];
      arr2_q <= mem[rd2_addr];
   end

   // Read address capture and last accepted write for bypass
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cap_vld_q <= 1'b0;
         cap1_q    <= '0;
         cap2_q    <= '0;
         pw_vld_q  <= 1'b0;
         pw_addr_q <= '0;
         pw_data_q <= 32'h0;
      end else begin
         cap_vld_q <= run;
         cap1_q    <= rd1_addr;
         cap2_q    <= rd2_addr;
         pw_vld_q  <= wr_acc;
         pw_addr_q <= wr_addr;
         pw_data_q <= new_rd;
      end
   end

   // Read data with same-hart bypass
   always_comb begin
      rs1 = rd_mux(cap_vld_q, cap1_q, arr1_q, wr_acc, wr_addr, new_rd,
                   pw_vld_q, pw_addr_q, pw_data_q);
      rs2 = rd_mux(cap_vld_q, cap2_q, arr2_q, wr_acc, wr_addr, new_rd,
                   pw_vld_q, pw_addr_q, pw_data_q);
   end

   // Hart scheduling and PCs; a taken branch overrides the sequential step
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < NPC; i++) pc_q[i] <= RESET_VECTOR;
         last_pc_q <= 32'h0;
         cur_q     <= '0;
      end else if (adv) begin
         last_pc_q    <= pc_cur - 32'd4;
         pc_q[cur_q]  <= pc_cur + 32'd4;
         cur_q        <= cur_nxt;
         if (update_pc) begin
            // the fetching hart has already consumed the target this cycle
            pc_q[wr_h] <= (wr_h == cur_q) ? (new_pc + 32'd4) : new_pc;
         end
      end
   end

   assign pc        = pc_cur;
   assign last_pc   = last_pc_q;
   assign cur_hart  = cur_q;
   assign init_done = init_done_q;

endmodule

// File: tb/tb_rv32_mt_regfile.sv
// ---------------------------------------------------------------------------
// tb_rv32_mt_regfile
// Directed bench for rv32_mt_regfile: two harts, 32 GPRs, RESET_VECTOR 0x1000.
// Inputs change 1 time unit after the rising edge; outputs are checked on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_rv32_mt_regfile;

   logic        clk;
   logic        reset_n;
   logic [4:0]  rs1_idx, rs2_idx, rd_idx;
   logic [0:0]  wr_hart;
   logic        rd_we;
   logic [31:0] new_rd;
   logic [31:0] new_pc;
   logic        update_pc;
   logic        stall;
   logic [31:0] rs1, rs2, pc, last_pc;
   logic [0:0]  cur_hart;
   logic        init_done;

   int tests;
   int fails;
   int n;

   rv32_mt_regfile #(
      .LOG2_REGFILE_ENTRIES(5),
      .LOG2_HARTS          (1),
      .RESET_VECTOR        (32'h0000_1000)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .rs1_idx  (rs1_idx),
      .rs2_idx  (rs2_idx),
      .rd_idx   (rd_idx),
      .wr_hart  (wr_hart),
      .rd_we    (rd_we),
      .new_rd   (new_rd),
      .new_pc   (new_pc),
      .update_pc(update_pc),
      .stall    (stall),
      .rs1      (rs1),
      .rs2      (rs2),
      .pc       (pc),
      .last_pc  (last_pc),
      .cur_hart (cur_hart),
      .init_done(init_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rd_we     = 1'b0;
      rd_idx    = 5'd0;
      wr_hart   = 1'b0;
      new_rd    = 32'h0;
      new_pc    = 32'h0;
      update_pc = 1'b0;
      stall     = 1'b0;
   endtask

   task automatic wr(input logic [0:0] h, input logic [4:0] idx, input logic [31:0] d);
      rd_we   = 1'b1;
      wr_hart = h;
      rd_idx  = idx;
      new_rd  = d;
   endtask

   task automatic br(input logic [0:0] h, input logic [31:0] tgt);
      update_pc = 1'b1;
      wr_hart   = h;
      new_pc    = tgt;
   endtask

   task automatic wait_init(input string tag);
      n = 0;
      do begin
         nxt();
         n++;
         if (n == 10) begin
            chk({tag, "_init_rs1"}, rs1, 32'h0);
            chk({tag, "_init_hart"}, 32'(cur_hart), 32'h0);
         end
      end while (!init_done && n < 200);
      chk({tag, "_init_len"}, 32'(n), 32'd64);
   endtask

   initial begin
      tests   = 0;
      fails   = 0;
      reset_n = 1'b0;
      rs1_idx = 5'd0;
      rs2_idx = 5'd0;
      idle();
      nxt();
      nxt();

      // reset state
      @(negedge clk);
      chk("rst_init_done", 32'(init_done), 32'h0);
      chk("rst_cur_hart",  32'(cur_hart),  32'h0);
      chk("rst_pc",        pc,             32'h0000_1000);
      chk("rst_last_pc",   last_pc,        32'h0);
      chk("rst_rs1",       rs1,            32'h0);
      chk("rst_rs2",       rs2,            32'h0);
      nxt();

      // INIT ignores writes, branches and stall
      reset_n = 1'b1;
      wr(1'b0, 5'd7, 32'h0000_1234);
      update_pc = 1'b1;
      new_pc    = 32'h0000_8000;
      stall     = 1'b1;
      wait_init("a");
      idle();
      rs1_idx = 5'd9;
      rs2_idx = 5'd31;

      // RUN cycles 0..5: round robin and sequential PC
      @(negedge clk);
      chk("c0_hart", 32'(cur_hart), 32'h0);
      chk("c0_pc",   pc,            32'h0000_1000);
      nxt();
      @(negedge clk);
      chk("c1_hart",    32'(cur_hart), 32'h1);
      chk("c1_pc",      pc,            32'h0000_1000);
      chk("c1_last_pc", last_pc,       32'h0000_0FFC);
      chk("c1_rs1",     rs1,           32'h0);
      chk("c1_rs2",     rs2,           32'h0);
      nxt();
      @(negedge clk);
      chk("c2_hart",    32'(cur_hart), 32'h0);
      chk("c2_pc",      pc,            32'h0000_1004);
      chk("c2_last_pc", last_pc,       32'h0000_0FFC);
      chk("c2_rs2",     rs2,           32'h0);
      nxt();
      @(negedge clk);
      chk("c3_hart",    32'(cur_hart), 32'h1);
      chk("c3_pc",      pc,            32'h0000_1004);
      chk("c3_last_pc", last_pc,       32'h0000_1000);
      chk("c3_rs1",     rs1,           32'h0);
      nxt();
      @(negedge clk);
      chk("c4_pc", pc, 32'h0000_1008);
      nxt();
      @(negedge clk);
      chk("c5_pc", pc, 32'h0000_1008);
      nxt();

      // c6: hart 0
      @(negedge clk);
      chk("c6_pc", pc, 32'h0000_100C);
      nxt();
      // c7: branch on the fetching hart
      br(1'b1, 32'h0000_0200);
      @(negedge clk);
      chk("c7_hart", 32'(cur_hart), 32'h1);
      chk("c7_pc",   pc,            32'h0000_100C);
      nxt();
      idle();
      @(negedge clk);
      chk("c8_pc", pc, 32'h0000_1010);
      nxt();
      @(negedge clk);
      chk("c9_pc_same_hart_br", pc,      32'h0000_0204);
      chk("c9_last_pc",         last_pc, 32'h0000_100C);
      nxt();
      // c10: branch for hart 1 while hart 0 fetches
      br(1'b1, 32'h0000_0200);
      @(negedge clk);
      chk("c10_pc", pc, 32'h0000_1014);
      nxt();
      idle();
      @(negedge clk);
      chk("c11_pc_other_hart_br", pc,      32'h0000_0200);
      chk("c11_last_pc",          last_pc, 32'h0000_1010);
      nxt();
      // c12: stalled cycle with write and branch attempts
      stall = 1'b1;
      br(1'b0, 32'h0000_4000);
      rd_we  = 1'b1;
      rd_idx = 5'd7;
      new_rd = 32'h0000_0077;
      @(negedge clk);
      chk("c12_pc", pc, 32'h0000_1018);
      chk("c12_last_pc", last_pc, 32'h0000_01FC);
      nxt();
      idle();
      rs1_idx = 5'd7;
      @(negedge clk);
      chk("c13_stall_hart",    32'(cur_hart), 32'h0);
      chk("c13_stall_pc",      pc,            32'h0000_1018);
      chk("c13_stall_last_pc", last_pc,       32'h0000_01FC);
      nxt();
      // c14: PC wrap through branch target
      br(1'b1, 32'hFFFF_FFFC);
      @(negedge clk);
      chk("c14_stall_no_write", rs1, 32'h0);
      nxt();
      idle();
      @(negedge clk);
      chk("c15_pc", pc, 32'h0000_101C);
      nxt();
      @(negedge clk);
      chk("c16_pc_wrap",  pc,      32'h0000_0000);
      chk("c16_last_pc",  last_pc, 32'h0000_1018);
      nxt();

      // D0 (hart 0): write x5 and read x5 in the same cycle
      wr(1'b0, 5'd5, 32'hDEAD_BEEF);
      rs1_idx = 5'd5;
      rs2_idx = 5'd5;
      @(negedge clk);
      chk("d0_last_pc_wrap", last_pc, 32'hFFFF_FFFC);
      chk("d0_pc",           pc,      32'h0000_1020);
      nxt();
      // D1 (hart 1)
      idle();
      @(negedge clk);
      chk("d1_rs1_prev_byp", rs1, 32'hDEAD_BEEF);
      chk("d1_rs2_prev_byp", rs2, 32'hDEAD_BEEF);
      nxt();
      // D2 (hart 0)
      @(negedge clk);
      chk("d2_rs1_hart1_x5", rs1, 32'h0);
      nxt();
      // D3 (hart 1)
      rs1_idx = 5'd6;
      rs2_idx = 5'd6;
      @(negedge clk);
      chk("d3_rs1_array", rs1, 32'hDEAD_BEEF);
      nxt();
      // D4 (hart 0): write hart1 x6 while the {1,6} read is presented
      wr(1'b1, 5'd6, 32'hCAFE_0001);
      rs1_idx = 5'd0;
      rs2_idx = 5'd0;
      @(negedge clk);
      chk("d4_rs1_cur_byp", rs1, 32'hCAFE_0001);
      chk("d4_rs2_cur_byp", rs2, 32'hCAFE_0001);
      nxt();
      // D5 (hart 1): x0 write attempt
      wr(1'b1, 5'd0, 32'hFFFF_FFFF);
      @(negedge clk);
      chk("d5_rs1_x0", rs1, 32'h0);
      nxt();
      // D6 (hart 0): x0 write while {1,0} is read
      wr(1'b0, 5'd0, 32'hFFFF_FFFF);
      @(negedge clk);
      chk("d6_rs1_x0_cur", rs1, 32'h0);
      nxt();
      // D7 (hart 1)
      idle();
      rs1_idx = 5'd5;
      @(negedge clk);
      chk("d7_rs1_x0_prev", rs1, 32'h0);
      nxt();
      // D8 (hart 0): write hart0 x5 while the {1,5} read is presented
      wr(1'b0, 5'd5, 32'h5555_5555);
      @(negedge clk);
      chk("d8_rs1_no_xhart_byp", rs1, 32'h0);
      nxt();
      // D9 (hart 1)
      idle();
      rs1_idx = 5'd6;
      @(negedge clk);
      chk("d9_rs1_prev_byp", rs1, 32'h5555_5555);
      nxt();
      // D10 (hart 0)
      rs1_idx = 5'd7;
      @(negedge clk);
      chk("d10_rs1_hart1_x6", rs1, 32'hCAFE_0001);
      nxt();
      // D11 (hart 1)
      @(negedge clk);
      chk("d11_rs1_x7", rs1, 32'h0);
      nxt();
      // D12 (hart 0): write x3
      wr(1'b0, 5'd3, 32'h3333_3333);
      nxt();
      // D13 (hart 1)
      idle();
      nxt();
      // D14 (hart 0)
      rs1_idx = 5'd3;
      nxt();
      // D15: reset while running
      @(negedge clk);
      chk("d15_rs1_x3", rs1, 32'h3333_3333);
      nxt();
      reset_n = 1'b0;
      nxt();
      @(negedge clk);
      chk("rst2_init_done", 32'(init_done), 32'h0);
      chk("rst2_cur_hart",  32'(cur_hart),  32'h0);
      chk("rst2_pc",        pc,             32'h0000_1000);
      chk("rst2_last_pc",   last_pc,        32'h0);
      chk("rst2_rs1",       rs1,            32'h0);
      nxt();

      // abort the clear sequence at INIT cycle 10
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) nxt();
      chk("abort_init_done", 32'(init_done), 32'h0);
      reset_n = 1'b0;
      nxt();
      reset_n = 1'b1;
      wait_init("b");
      rs1_idx = 5'd3;
      @(negedge clk);
      chk("b_c0_pc", pc, 32'h0000_1000);
      nxt();
      @(negedge clk);
      chk("b_c1_rs1_x3_cleared", rs1, 32'h0);
      nxt();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rv32_mt_regfile.md
RV32_MT_REGFILE -- requirements
Module: rv32_mt_regfile

Interface
REQ-001 SHALL have parameter LOG2_REGFILE_ENTRIES, default 5, meaning log2 of GPRs per hart (4 = RV32E, 5 = RV32I).
REQ-002 SHALL have parameter LOG2_HARTS, default 1, meaning log2 of hart count; the legal range is 0..3.
REQ-003 SHALL have parameter RESET_VECTOR, default 32'h00000000, meaning the initial PC of every hart.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 reset_n  input  1  reset, synchronous, active-low.
REQ-006 rs1_idx, rs2_idx  input  5 each  read indices for cur_hart; bits above LOG2_REGFILE_ENTRIES ignored.
REQ-007 rd_idx  input  5  write index.
REQ-008 wr_hart  input  max(LOG2_HARTS,1)  hart owning the write and the PC update.
REQ-009 rd_we  input  1  write enable.
REQ-010 new_rd  input  32  write data.
REQ-011 new_pc, update_pc  input  32/1  branch target and branch-taken strobe for wr_hart.
REQ-012 stall  input  1  freezes hart scheduling, PC update and writes.
REQ-013 rs1, rs2  output  32  read data, valid one cycle after the index is presented.
REQ-014 pc, last_pc  output  32  PC of cur_hart, and cur_hart's PC-4 registered at the last advance.
REQ-015 cur_hart  output  max(LOG2_HARTS,1)  hart currently being fetched.
REQ-016 init_done  output  1  high when register clearing is complete.

Function
REQ-017 Storage SHALL be 2^(LOG2_REGFILE_ENTRIES+LOG2_HARTS) x 32 bits, addressed {hart, index}.
REQ-018 FSM states SHALL be INIT and RUN; reset forces INIT with clear counter 0.
REQ-019 In INIT, after reset release, one entry per cycle SHALL be written with 0, in ascending address order.
REQ-020 The FSM SHALL go to RUN, with init_done=1, on the cycle after the last entry is written; INIT lasts 2^(LOG2_REGFILE_ENTRIES+LOG2_HARTS) cycles.
REQ-021 In INIT, rd_we, update_pc and stall SHALL be ignored, rs1/rs2 SHALL read 0, and cur_hart SHALL stay 0.
REQ-022 In RUN, a write SHALL occur when rd_we=1, stall=0 and rd_idx!=0 (and rd_idx < 2^LOG2_REGFILE_ENTRIES); otherwise no write occurs.
REQ-023 Reads SHALL capture {cur_hart, rs_idx} every RUN cycle and present data the next cycle; index 0 SHALL always return 0.
REQ-024 rs1/rs2 bypass priority: captured {hart, idx} equals the current-cycle accepted write -> new_rd; else equals the previous-cycle accepted write -> that write's data; else array data.
REQ-025 Writes to a different hart SHALL never bypass.
REQ-026 In RUN with stall=0, cur_hart SHALL advance round-robin (wrapping from 2^LOG2_HARTS-1 to 0); with LOG2_HARTS=0 it SHALL stay 0.
REQ-027 In RUN with stall=0, last_pc SHALL get pc-4 and the cur_hart PC SHALL get pc+4.
REQ-028 When update_pc=1, the wr_hart PC SHALL get new_pc+4 if wr_hart==cur_hart, else new_pc.
REQ-029 All PC arithmetic SHALL be modulo 2^32.
REQ-030 With stall=1 in RUN, all PCs, cur_hart and the array SHALL hold; read capture SHALL continue.

Reset
REQ-031 On reset, every hart PC SHALL be RESET_VECTOR, and last_pc, rs1, rs2, cur_hart and init_done SHALL be 0.
REQ-032 Reset asserted mid-INIT or mid-RUN SHALL abort and restart the clear sequence from entry 0 after release.

Verification
REQ-033 Defaults, reset released at t0 -> init_done rises at t0+64; a read of any {hart, idx} afterwards returns 0.
REQ-034 Write x5=32'hDEADBEEF on hart 0, same cycle as a read of x5 on hart 0 -> rs1=32'hDEADBEEF next cycle; the same read from hart 1 returns 0.
REQ-035 Write x0=32'hFFFFFFFF with rd_we=1 -> a later read of x0 returns 0, including the bypass cycle.
REQ-036 RESET_VECTOR=32'h1000, two harts, no stalls -> cur_hart toggles 0,1,0,1 and each hart's pc steps 32'h1000, 32'h1004, ...
REQ-037 update_pc=1, new_pc=32'h200, wr_hart=1 while cur_hart=1 -> hart-1 pc=32'h204; the same with cur_hart=0 -> hart-1 pc=32'h200 and hart-0 pc+4.
REQ-038 Reset pulsed at INIT cycle 10, after x3 was written earlier -> x3 reads 0 after the new init_done, which comes 64 cycles after release.
